// File: rtl/nway_miss_ctrl_if.sv
// Lookup-request and memory-refill bus of the 4-way miss controller.
// slave: the controller's view. master: the upstream/memory environment.
interface nway_miss_ctrl_if #(
  parameter int TAG_W = 24
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [3:0]       req_set_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             req_hit_i;
  logic [1:0]       req_hit_way_i;
  logic [3:0]       req_way_valid_i;

  logic             mem_req_valid_o;
  logic             mem_req_ready_i;
  logic [TAG_W-1:0] mem_req_tag_o;
  logic [3:0]       mem_req_set_o;
  logic             mem_resp_valid_i;

  modport slave (
    input  req_valid_i, req_set_i, req_tag_i, req_hit_i, req_hit_way_i, req_way_valid_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_tag_o, mem_req_set_o,
    input  mem_req_ready_i, mem_resp_valid_i
  );

  modport master (
    output req_valid_i, req_set_i, req_tag_i, req_hit_i, req_hit_way_i, req_way_valid_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_tag_o, mem_req_set_o,
    output mem_req_ready_i, mem_resp_valid_i
  );
endinterface

// File: rtl/nway_miss_ctrl.sv
// Miss/hit sequencing controller for a 4-way, 16-set cache.
// Hits mark the hit way MRU; misses pick a fill way (lowest invalid way,
// else the LRU victim), refill from memory, write the way and mark it MRU.
// Optional macro NWAY_MISS_CTRL_PERF_EN adds saturating hit/miss counters.
module nway_miss_ctrl #(
  parameter int TAG_W      = 24,
  parameter int VICTIM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  nway_miss_ctrl_if.slave bus,
  output logic [3:0]  lru_set_o,
  output logic [1:0]  lru_way_o,
  output logic        lru_access_o,
  output logic        lru_update_o,
  input  logic [1:0]  lru_victim_i,
  output logic        fill_we_o,
  output logic [1:0]  fill_way_o,
  output logic        resp_valid_o,
  output logic        resp_hit_o
`ifdef NWAY_MISS_CTRL_PERF_EN
  ,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o
`endif
);

  localparam int CNT_W = (VICTIM_LAT < 2) ? 1 : $clog2(VICTIM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VICTIM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HIT, S_VICTIM, S_MEM_REQ, S_MEM_WAIT, S_FILL
  } state_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic [3:0]       set_q, set_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       hit_way_q, hit_way_d;
  logic [3:0]       valid_q, valid_d;
  logic [1:0]       fill_way_q, fill_way_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       low_inv;
  logic             accept;

  // live_q keeps ready low while reset is held and rises on the first clock after release
  assign accept = (state_q == S_IDLE) && live_q && bus.req_valid_i;

  // Lowest-index invalid way of the latched valid bits
  always_comb begin
    low_inv = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) low_inv = 2'(i);
    end
  end

  // State and latched transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      live_q     <= 1'b0;
      set_q      <= '0;
      tag_q      <= '0;
      hit_way_q  <= '0;
      valid_q    <= '0;
      fill_way_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      set_q      <= set_d;
      tag_q      <= tag_d;
      hit_way_q  <= hit_way_d;
      valid_q    <= valid_d;
      fill_way_q <= fill_way_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and latch/victim-selection logic
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    tag_d      = tag_q;
    hit_way_d  = hit_way_q;
    valid_d    = valid_q;
    fill_way_d = fill_way_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          set_d     = bus.req_set_i;
          tag_d     = bus.req_tag_i;
          hit_way_d = bus.req_hit_way_i;
          valid_d   = bus.req_way_valid_i;
          cnt_d     = '0;
          state_d   = bus.req_hit_i ? S_HIT : S_VICTIM;
        end
      end
      S_HIT: state_d = S_IDLE;
      S_VICTIM: begin
        if (!(&valid_q)) begin
          fill_way_d = low_inv;
          state_d    = S_MEM_REQ;
        end else if (cnt_q == CNT_LAST) begin
          fill_way_d = lru_victim_i;
          state_d    = S_MEM_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MEM_REQ:  if (bus.mem_req_ready_i)  state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (bus.mem_resp_valid_i) state_d = S_FILL;
      S_FILL:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    bus.req_ready_o     = (state_q == S_IDLE) && live_q;
    bus.mem_req_valid_o = (state_q == S_MEM_REQ);
    bus.mem_req_tag_o   = tag_q;
    bus.mem_req_set_o   = set_q;
    lru_set_o           = set_q;
    lru_way_o           = 2'd0;
    lru_access_o        = 1'b0;
    lru_update_o        = 1'b0;
    fill_we_o           = 1'b0;
    fill_way_o          = 2'd0;
    resp_valid_o        = 1'b0;
    resp_hit_o          = 1'b0;
    case (state_q)
      S_HIT: begin
        lru_way_o    = hit_way_q;
        lru_access_o = 1'b1;
        resp_valid_o = 1'b1;
        resp_hit_o   = 1'b1;
      end
      S_FILL: begin
        lru_way_o    = fill_way_q;
        lru_update_o = 1'b1;
        fill_we_o    = 1'b1;
        fill_way_o   = fill_way_q;
        resp_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef NWAY_MISS_CTRL_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  // Saturating hit/miss completion counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (state_q == S_HIT && perf_hit_q != 32'hFFFF_FFFF)   perf_hit_q  <= perf_hit_q + 32'd1;
      if (state_q == S_FILL && perf_miss_q != 32'hFFFF_FFFF) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_nway_miss_ctrl.sv
// Directed plus randomized bench for nway_miss_ctrl with a transaction-level model.
module tb_nway_miss_ctrl;
  localparam int TAG_W = 24;
  localparam int VL    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nway_miss_ctrl_if #(.TAG_W(TAG_W)) bus ();

  logic [3:0]  lru_set_o;
  logic [1:0]  lru_way_o;
  logic        lru_access_o, lru_update_o;
  logic [1:0]  lru_victim_i;
  logic        fill_we_o;
  logic [1:0]  fill_way_o;
  logic        resp_valid_o, resp_hit_o;
`ifdef NWAY_MISS_CTRL_PERF_EN
  logic [31:0] perf_hit_o, perf_miss_o;
`endif

  nway_miss_ctrl #(.TAG_W(TAG_W), .VICTIM_LAT(VL)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .lru_set_o    (lru_set_o),
    .lru_way_o    (lru_way_o),
    .lru_access_o (lru_access_o),
    .lru_update_o (lru_update_o),
    .lru_victim_i (lru_victim_i),
    .fill_we_o    (fill_we_o),
    .fill_way_o   (fill_way_o),
    .resp_valid_o (resp_valid_o),
    .resp_hit_o   (resp_hit_o)
`ifdef NWAY_MISS_CTRL_PERF_EN
    ,
    .perf_hit_o   (perf_hit_o),
    .perf_miss_o  (perf_miss_o)
`endif
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int n_hit  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ready"},    32'(bus.req_ready_o), 0);
    check({pfx, "_mreq_v"},   32'(bus.mem_req_valid_o), 0);
    check({pfx, "_mreq_set"}, 32'(bus.mem_req_set_o), 0);
    check({pfx, "_mreq_tag"}, 32'(bus.mem_req_tag_o), 0);
    check({pfx, "_lru_set"},  32'(lru_set_o), 0);
    check({pfx, "_lru_way"},  32'(lru_way_o), 0);
    check({pfx, "_access"},   32'(lru_access_o), 0);
    check({pfx, "_update"},   32'(lru_update_o), 0);
    check({pfx, "_fill_we"},  32'(fill_we_o), 0);
    check({pfx, "_fill_way"}, 32'(fill_way_o), 0);
    check({pfx, "_resp_v"},   32'(resp_valid_o), 0);
    check({pfx, "_resp_hit"}, 32'(resp_hit_o), 0);
  endtask

  // Waits for ready, presents one request for a single accept cycle.
  // Returns at the falling edge of the cycle after acceptance.
  task automatic send_req(input logic [3:0] set, input logic [TAG_W-1:0] tag,
                          input logic hit, input logic [1:0] hway, input logic [3:0] valid);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(bus.req_ready_o), 1);
    bus.req_set_i       = set;
    bus.req_tag_i       = tag;
    bus.req_hit_i       = hit;
    bus.req_hit_way_i   = hway;
    bus.req_way_valid_i = valid;
    bus.req_valid_i     = 1'b1;
    @(negedge clk);
    bus.req_valid_i     = 1'b0;
    $display("txn set=%0d tag=%06h hit=%0b way=%0d valid=%04b", set, tag, hit, hway, valid);
  endtask

  task automatic hit_flow(input logic [3:0] set, input logic [1:0] hway);
    check("hit_resp_v",  32'(resp_valid_o), 1);
    check("hit_resp_h",  32'(resp_hit_o), 1);
    check("hit_access",  32'(lru_access_o), 1);
    check("hit_update",  32'(lru_update_o), 0);
    check("hit_lru_set", 32'(lru_set_o), 32'(set));
    check("hit_lru_way", 32'(lru_way_o), 32'(hway));
    check("hit_fill_we", 32'(fill_we_o), 0);
    n_hit++;
    @(negedge clk);
    check("hit_ready_after", 32'(bus.req_ready_o), 1);
    check("hit_resp_drop",   32'(resp_valid_o), 0);
  endtask

  task automatic miss_flow(input logic [3:0] set, input logic [TAG_W-1:0] tag,
                           input logic [3:0] valid, input logic [1:0] victim,
                           input int rdly, input int respdly);
    int exp_lat = (valid == 4'hF) ? 1 + VL : 2;
    int k = 1;
    logic [1:0] exp_way = victim;
    bit found = 0;
    for (int i = 0; i < 4; i++) begin
      if (!valid[i] && !found) begin
        exp_way = 2'(i);
        found   = 1;
      end
    end
    while (!bus.mem_req_valid_o && k < 20) begin
      lru_victim_i = (k >= exp_lat - 1) ? victim : ~victim;
      @(negedge clk);
      k++;
    end
    check("mreq_latency", 32'(k), 32'(exp_lat));
    for (int c = 0; c <= rdly; c++) begin
      check("mreq_valid", 32'(bus.mem_req_valid_o), 1);
      check("mreq_set",   32'(bus.mem_req_set_o), 32'(set));
      check("mreq_tag",   32'(bus.mem_req_tag_o), 32'(tag));
      if (c == rdly) bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
    end
    bus.mem_req_ready_i = 1'b0;
    check("mreq_drop", 32'(bus.mem_req_valid_o), 0);
    repeat (respdly) @(negedge clk);
    check("wait_no_fill", 32'(fill_we_o), 0);
    check("wait_lru_set", 32'(lru_set_o), 32'(set));
    bus.mem_resp_valid_i = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid_i = 1'b0;
    check("fill_we",     32'(fill_we_o), 1);
    check("fill_way",    32'(fill_way_o), 32'(exp_way));
    check("fill_update", 32'(lru_update_o), 1);
    check("fill_access", 32'(lru_access_o), 0);
    check("fill_lruway", 32'(lru_way_o), 32'(exp_way));
    check("fill_resp_v", 32'(resp_valid_o), 1);
    check("fill_resp_h", 32'(resp_hit_o), 0);
    n_miss++;
    @(negedge clk);
    check("miss_ready_after", 32'(bus.req_ready_o), 1);
    check("miss_resp_drop",   32'(resp_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid_i      = 1'b0;
    bus.req_set_i        = '0;
    bus.req_tag_i        = '0;
    bus.req_hit_i        = 1'b0;
    bus.req_hit_way_i    = '0;
    bus.req_way_valid_i  = '0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_resp_valid_i = 1'b0;
    lru_victim_i         = '0;

    // Power-on reset state
    #13;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("por_ready", 32'(bus.req_ready_o), 1);

    // Reset while a refill request is outstanding
    send_req(4'd3, 24'hABCDEF, 1'b0, 2'd0, 4'b0000);
    @(negedge clk);
    check("rst_mreq_before", 32'(bus.mem_req_valid_o), 1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    n_hit  = 0;
    n_miss = 0;
    @(negedge clk);
    check("rst_ready_after", 32'(bus.req_ready_o), 1);

    // Hit, set 5 way 2
    send_req(4'd5, 24'h000055, 1'b1, 2'd2, 4'b1111);
    hit_flow(4'd5, 2'd2);

    // Miss with an invalid way: fill way 2, no victim wait
    send_req(4'd3, 24'h123456, 1'b0, 2'd0, 4'b1011);
    miss_flow(4'd3, 24'h123456, 4'b1011, 2'd0, 0, 1);

    // Miss on a full set: victim 1, memory stalls the request for 3 cycles
    send_req(4'd9, 24'h999999, 1'b0, 2'd0, 4'b1111);
    miss_flow(4'd9, 24'h999999, 4'b1111, 2'd1, 3, 2);

    // Request held during a miss is accepted exactly once afterwards
    begin
      int guard = 0;
      int resp_cnt = 0;
      bit ready_seen = 0;
      bit hs = 0;
      bit sent = 0;
      @(negedge clk);
      while (!bus.req_ready_o && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      bus.req_set_i       = 4'd6;
      bus.req_tag_i       = 24'h060606;
      bus.req_hit_i       = 1'b0;
      bus.req_way_valid_i = 4'b0111;
      bus.req_valid_i     = 1'b1;
      @(negedge clk);
      $display("txn held miss set=6 then hit set=12 way=1");
      bus.req_set_i       = 4'd12;
      bus.req_tag_i       = 24'h0C0C0C;
      bus.req_hit_i       = 1'b1;
      bus.req_hit_way_i   = 2'd1;
      bus.req_way_valid_i = 4'b1111;
      guard = 0;
      while (!fill_we_o && guard < 40) begin
        if (bus.req_ready_o) ready_seen = 1;
        bus.mem_resp_valid_i = hs && !sent;
        if (hs) sent = 1;
        hs = bus.mem_req_valid_o;
        bus.mem_req_ready_i = bus.mem_req_valid_o;
        @(negedge clk);
        bus.mem_resp_valid_i = 1'b0;
        guard++;
      end
      bus.mem_req_ready_i = 1'b0;
      check("held_fill",        32'(fill_we_o), 1);
      check("held_fill_way",    32'(fill_way_o), 3);
      check("held_ready_low",   32'(ready_seen), 0);
      check("held_ready_fill",  32'(bus.req_ready_o), 0);
      n_miss++;
      @(negedge clk);
      check("held_ready_after", 32'(bus.req_ready_o), 1);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("held_hit",     32'(resp_hit_o), 1);
      check("held_hit_set", 32'(lru_set_o), 12);
      n_hit++;
      repeat (6) begin
        @(negedge clk);
        if (resp_valid_o) resp_cnt++;
      end
      check("held_once", 32'(resp_cnt), 0);
    end

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [3:0]       set   = 4'($urandom);
      logic [TAG_W-1:0] tag   = TAG_W'($urandom);
      logic             hit   = 1'($urandom);
      logic [1:0]       hway  = 2'($urandom);
      logic [3:0]       valid = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      logic [1:0]       vic   = 2'($urandom);
      lru_victim_i = 2'($urandom);
      send_req(set, tag, hit, hway, valid);
      if (hit) hit_flow(set, hway);
      else     miss_flow(set, tag, valid, vic, $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef NWAY_MISS_CTRL_PERF_EN
    check("perf_hit",  perf_hit_o,  32'(n_hit));
    check("perf_miss", perf_miss_o, 32'(n_miss));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
